// File: rtl/usb_rx_link_ctrl.sv
// Receive-side link sequencer for OUT/SETUP transactions: token -> DATA PID check ->
// payload end -> ACK/NAK decision, with per-endpoint data toggle and SOP timeout.
module usb_rx_link_ctrl #(
    parameter int NUM_EP      = 4,
    parameter int TIMEOUT_CYC = 90,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              token_valid,
    input  logic              token_is_setup,
    input  logic [3:0]        token_endp,
    input  logic              rx_abort,
    output logic              rx_data_on,
    input  logic              rx_sop_en,
    input  logic [7:0]        rx_pid_byte,
    input  logic              rx_lt_eop_en,
    input  logic              crc16_err,
    input  logic              ep_nak,
    output logic              hs_valid,
    output logic [7:0]        hs_pid,
    output logic              xfer_ok,
    output logic [3:0]        xfer_endp,
    output logic              rx_timeout,
    output logic              pid_err,
    output logic              busy,
    output logic [NUM_EP-1:0] ep_toggle
);

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    typedef enum logic [1:0] {IDLE, WAIT_SOP, RECV, HS} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              is_setup, is_setup_d;
    logic              pid_tog, pid_tog_d;
    logic [3:0]        endp_d;
    logic [NUM_EP-1:0] tog_d;
    logic              hs_valid_d, xfer_ok_d, rx_timeout_d, pid_err_d;
    logic [7:0]        hs_pid_d;
    logic              cur_tog;
    logic              tog_wr;
    logic              tog_val;

    always_comb begin
        cur_tog = 1'b0;
        for (int i = 0; i < NUM_EP; i++)
            if (32'(xfer_endp) == i) cur_tog = ep_toggle[i];
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        is_setup_d   = is_setup;
        pid_tog_d    = pid_tog;
        endp_d       = xfer_endp;
        hs_valid_d   = 1'b0;
        hs_pid_d     = 8'h00;
        xfer_ok_d    = 1'b0;
        rx_timeout_d = 1'b0;
        pid_err_d    = 1'b0;
        tog_wr       = 1'b0;
        tog_val      = 1'b0;
        if (rx_abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (token_valid && (32'(token_endp) < NUM_EP)) begin
                        endp_d     = token_endp;
                        is_setup_d = token_is_setup;
                        cnt_d      = '0;
                        state_d    = WAIT_SOP;
                    end
                end
                WAIT_SOP: begin
                    cnt_d = cnt + 1'b1;
                    if (rx_sop_en) begin
                        if (rx_pid_byte == PID_DATA0 || rx_pid_byte == PID_DATA1) begin
                            pid_tog_d = (rx_pid_byte == PID_DATA1);
                            state_d   = RECV;
                        end else begin
                            pid_err_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rx_timeout_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
                RECV: begin
                    // Decision is registered on the EOP edge so the handshake
                    // is visible during the single HS cycle.
                    if (rx_lt_eop_en) begin
                        state_d = HS;
                        if (crc16_err) begin
                            hs_valid_d = 1'b0;
                        end else if (is_setup && pid_tog) begin
                            pid_err_d = 1'b1;
                        end else if (is_setup) begin
                            hs_valid_d = 1'b1;
                            hs_pid_d   = PID_ACK;
                            xfer_ok_d  = 1'b1;
                            tog_wr     = 1'b1;
                            tog_val    = 1'b1;
                        end else if (ep_nak) begin
                            hs_valid_d = 1'b1;
                            hs_pid_d   = PID_NAK;
                        end else if (pid_tog != cur_tog) begin
                            hs_valid_d = 1'b1;
                            hs_pid_d   = PID_ACK;
                        end else begin
                            hs_valid_d = 1'b1;
                            hs_pid_d   = PID_ACK;
                            xfer_ok_d  = 1'b1;
                            tog_wr     = 1'b1;
                            tog_val    = ~cur_tog;
                        end
                    end
                end
                HS: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tog_d = ep_toggle;
        for (int i = 0; i < NUM_EP; i++)
            if (tog_wr && 32'(xfer_endp) == i) tog_d[i] = tog_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_setup   <= 1'b0;
            pid_tog    <= 1'b0;
            xfer_endp  <= 4'd0;
            ep_toggle  <= '0;
            hs_valid   <= 1'b0;
            hs_pid     <= 8'h00;
            xfer_ok    <= 1'b0;
            rx_timeout <= 1'b0;
            pid_err    <= 1'b0;
            busy       <= 1'b0;
            rx_data_on <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            is_setup   <= is_setup_d;
            pid_tog    <= pid_tog_d;
            xfer_endp  <= endp_d;
            ep_toggle  <= tog_d;
            hs_valid   <= hs_valid_d;
            hs_pid     <= hs_pid_d;
            xfer_ok    <= xfer_ok_d;
            rx_timeout <= rx_timeout_d;
            pid_err    <= pid_err_d;
            busy       <= (state_d != IDLE);
            rx_data_on <= (state_d == WAIT_SOP) || (state_d == RECV);
        end
    end

endmodule

// File: tb/tb_usb_rx_link_ctrl.sv
// Bench for usb_rx_link_ctrl: directed transactions then randomized ones, each
// checked against a transaction-level model of the toggle/handshake rules.
module tb_usb_rx_link_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       token_valid, token_is_setup, rx_abort;
    logic [3:0] token_endp;
    logic       rx_data_on, rx_sop_en, rx_lt_eop_en, crc16_err, ep_nak;
    logic [7:0] rx_pid_byte;
    logic       hs_valid, xfer_ok, rx_timeout, pid_err, busy;
    logic [7:0] hs_pid;
    logic [3:0] xfer_endp;
    logic [3:0] ep_toggle;

    int total = 0;
    int bad   = 0;
    logic [3:0] mt;
    logic [3:0] last_endp;

    usb_rx_link_ctrl #(.NUM_EP(4), .TIMEOUT_CYC(90), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .token_valid(token_valid), .token_is_setup(token_is_setup), .token_endp(token_endp),
        .rx_abort(rx_abort), .rx_data_on(rx_data_on),
        .rx_sop_en(rx_sop_en), .rx_pid_byte(rx_pid_byte),
        .rx_lt_eop_en(rx_lt_eop_en), .crc16_err(crc16_err), .ep_nak(ep_nak),
        .hs_valid(hs_valid), .hs_pid(hs_pid), .xfer_ok(xfer_ok), .xfer_endp(xfer_endp),
        .rx_timeout(rx_timeout), .pid_err(pid_err), .busy(busy), .ep_toggle(ep_toggle)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        token_valid = 0; token_is_setup = 0; token_endp = 0; rx_abort = 0;
        rx_sop_en = 0; rx_pid_byte = 0; rx_lt_eop_en = 0; crc16_err = 0; ep_nak = 0;
    endtask

    // mode: 0 normal, 1 timeout, 2 abort in RECV, 3 abort in WAIT_SOP
    task automatic txn(input logic [3:0] endp, input bit setup, input int mode,
                       input logic [7:0] pid, input bit crc, input bit nak,
                       input int gap, input int gap2);
        bit       ptog, e_hs, e_xok, e_perr;
        logic [7:0] e_pid;
        int       k;
        token_valid = 1; token_is_setup = setup; token_endp = endp;
        cyc();
        idle_inputs();
        if (endp >= 4) begin
            chk("bad_endp_busy", busy, 0);
            chk("bad_endp_endp", xfer_endp, last_endp);
            cyc();
            chk("bad_endp_busy2", busy, 0);
            return;
        end
        last_endp = endp;
        chk("tok_busy", busy, 1);
        chk("tok_data_on", rx_data_on, 1);
        chk("tok_endp", xfer_endp, endp);
        if (mode == 1) begin
            for (k = 1; k <= 200; k++) begin
                cyc();
                if (rx_timeout) break;
                if (k == 89) chk("to_data_on_before", rx_data_on, 1);
            end
            chk("to_cycle", k, 90);
            chk("to_data_on", rx_data_on, 0);
            chk("to_busy", busy, 0);
            cyc();
            chk("to_pulse", rx_timeout, 0);
            return;
        end
        for (int i = 0; i < gap; i++) begin
            token_valid = 1'($urandom); token_endp = 4'($urandom_range(0, 3));
            rx_pid_byte = 8'($urandom);
            cyc();
            chk("wait_no_to", rx_timeout, 0);
        end
        idle_inputs();
        if (mode == 3) begin
            rx_abort = 1; rx_sop_en = 1; rx_pid_byte = 8'hC3;
            cyc();
            idle_inputs();
            chk("abw_busy", busy, 0);
            chk("abw_data_on", rx_data_on, 0);
            chk("abw_perr", pid_err, 0);
            return;
        end
        rx_sop_en = 1; rx_pid_byte = pid;
        cyc();
        idle_inputs();
        if (pid != 8'hC3 && pid != 8'h4B) begin
            chk("perr_sop", pid_err, 1);
            chk("perr_busy", busy, 0);
            chk("perr_data_on", rx_data_on, 0);
            return;
        end
        chk("sop_busy", busy, 1);
        chk("sop_data_on", rx_data_on, 1);
        chk("sop_timeout", rx_timeout, 0);
        ptog = (pid == 8'h4B);
        for (int i = 0; i < gap2; i++) cyc();
        chk("recv_busy", busy, 1);
        if (mode == 2) begin
            rx_abort = 1; rx_lt_eop_en = 1;
            cyc();
            idle_inputs();
            chk("abr_busy", busy, 0);
            chk("abr_hs", hs_valid, 0);
            chk("abr_xok", xfer_ok, 0);
            chk("abr_tog", ep_toggle, mt);
            return;
        end
        rx_lt_eop_en = 1; crc16_err = crc; ep_nak = nak;
        cyc();
        idle_inputs();
        e_hs = 0; e_pid = 8'h00; e_xok = 0; e_perr = 0;
        if (crc) begin
            e_hs = 0;
        end else if (setup) begin
            if (ptog) e_perr = 1;
            else begin e_hs = 1; e_pid = 8'hD2; e_xok = 1; mt[endp[1:0]] = 1'b1; end
        end else if (nak) begin
            e_hs = 1; e_pid = 8'h5A;
        end else begin
            e_hs = 1; e_pid = 8'hD2;
            if (ptog == mt[endp[1:0]]) begin e_xok = 1; mt[endp[1:0]] = ~ptog; end
        end
        chk("hs_valid", hs_valid, e_hs);
        chk("hs_pid", hs_pid, e_pid);
        chk("xfer_ok", xfer_ok, e_xok);
        chk("hs_perr", pid_err, e_perr);
        chk("hs_busy", busy, 1);
        chk("hs_data_on", rx_data_on, 0);
        chk("hs_tog", ep_toggle, mt);
        chk("hs_endp", xfer_endp, endp);
        cyc();
        chk("post_busy", busy, 0);
        chk("post_hs", hs_valid, 0);
        chk("post_xok", xfer_ok, 0);
    endtask

    initial begin
        int mode;
        logic [7:0] pid;
        idle_inputs();
        rst = 1; mt = 0; last_endp = 0;
        cyc(); cyc();
        chk("rst_outs", {hs_valid, hs_pid, xfer_ok, xfer_endp, rx_timeout, pid_err, busy, rx_data_on, ep_toggle}, 0);
        rst = 0;
        cyc();
        chk("rst_idle_busy", busy, 0);

        txn(4'd1, 0, 0, 8'hC3, 0, 0, 3, 2);
        chk("ep1_tog_set", ep_toggle[1], 1);
        txn(4'd1, 0, 0, 8'hC3, 0, 0, 1, 0);
        chk("ep1_dup_keep", ep_toggle[1], 1);
        txn(4'd0, 0, 0, 8'hC3, 0, 0, 0, 1);
        txn(4'd0, 1, 0, 8'hC3, 0, 0, 2, 1);
        chk("ep0_setup_tog", ep_toggle[0], 1);
        txn(4'd0, 0, 0, 8'h4B, 0, 0, 0, 0);
        chk("ep0_out_tog", ep_toggle[0], 0);
        txn(4'd2, 0, 0, 8'hC3, 0, 1, 1, 1);
        txn(4'd2, 0, 0, 8'hC3, 1, 0, 1, 1);
        chk("ep2_crc_tog", ep_toggle[2], 0);
        txn(4'd3, 0, 1, 8'hC3, 0, 0, 0, 0);
        txn(4'd3, 0, 0, 8'hD2, 0, 0, 2, 0);
        txn(4'd1, 0, 2, 8'h4B, 0, 0, 2, 3);
        txn(4'd5, 0, 0, 8'hC3, 0, 0, 0, 0);
        txn(4'd2, 1, 0, 8'h4B, 0, 0, 0, 0);
        txn(4'd3, 0, 0, 8'hC3, 0, 0, 89, 120);
        txn(4'd3, 0, 3, 8'hC3, 0, 0, 40, 0);

        for (int n = 0; n < 250; n++) begin
            mode = $urandom_range(0, 19);
            if (mode > 3) mode = 0;
            pid = ($urandom_range(0, 1) == 1) ? 8'h4B : 8'hC3;
            if ($urandom_range(0, 9) == 0) pid = 8'($urandom);
            txn(4'($urandom_range(0, 5)), 1'($urandom_range(0, 3) == 0), mode, pid,
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
                $urandom_range(0, 89), $urandom_range(0, 5));
        end

        token_valid = 1; token_endp = 4'd1; cyc(); idle_inputs();
        rx_sop_en = 1; rx_pid_byte = 8'hC3; cyc(); idle_inputs();
        #2 rst = 1; #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_data_on", rx_data_on, 0);
        chk("midrst_tog", ep_toggle, 0);
        chk("midrst_endp", xfer_endp, 0);
        cyc();
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
